// File: rtl/nrzi_rx_decoder.sv
// nrzi_rx_decoder: NRZI receive decoder with zero-unstuffing and LSB-first
// word assembly, delivering words on a valid/ready output port.
//
// Output handshake: out_valid is raised when a word loads into out_data and
// stays high, with out_data unchanged, until the cycle in which out_valid &&
// out_ready is seen at a rising clk edge; the word is then consumed and
// out_valid drops on the next cycle unless a new word loads on that same edge.
// A word completing while out_valid && !out_ready is dropped and flagged on
// overrun.
module nrzi_rx_decoder #(
    parameter int   WIDTH      = 8,
    parameter int   STUFF_LEN  = 6,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_en,
    input  logic             bit_en,
    input  logic             line_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             stuff_err,
    output logic             overrun,
    output logic             state_dbg
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int OCW = $clog2(STUFF_LEN + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             prev_q, prev_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [OCW-1:0]   ones_q, ones_d;
    logic [WIDTH-1:0] data_d;
    logic             valid_d;
    logic             stuff_d;
    logic             ovr_d;
    logic             dec_bit;
    logic [WIDTH-1:0] word;

    // Debug view of the FSM: 1 while receiving a frame.
    assign state_dbg = (state_q == RECV);

    // NRZI: an unchanged line level means a 1, a transition means a 0.
    assign dec_bit = (line_in == prev_q);
    assign word    = {dec_bit, shift_q[WIDTH-1:1]};

    // Next-state, decode, unstuff and output-port logic.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        data_d    = out_data;
        valid_d   = out_valid;
        stuff_d   = 1'b0;
        ovr_d     = 1'b0;

        // Consumer took the word; a load below may re-raise out_valid.
        if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rx_en) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (!rx_en) begin
                    // Abort: discard the partial word and restart line tracking.
                    state_d   = IDLE;
                    prev_d    = IDLE_LEVEL;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    ones_d    = '0;
                end else if (bit_en) begin
                    prev_d = line_in;
                    if (ones_q == OCW'(STUFF_LEN)) begin
                        // Stuff slot: never data. A 1 here breaks the stuffing rule.
                        ones_d = '0;
                        if (dec_bit) begin
                            stuff_d   = 1'b1;
                            shift_d   = '0;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        ones_d = dec_bit ? ones_q + 1'b1 : '0;
                        if (bit_cnt_q == BCW'(WIDTH - 1)) begin
                            // Word complete; the ones run deliberately carries over.
                            bit_cnt_d = '0;
                            shift_d   = '0;
                            if (!out_valid || out_ready) begin
                                data_d  = word;
                                valid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            shift_d   = word;
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prev_q    <= IDLE_LEVEL;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            stuff_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            stuff_err <= stuff_d;
            overrun   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// tb_nrzi_rx_decoder: drives payload words through a bench-side stuffing NRZI
// encoder and checks the decoded words, pulses and handshake behaviour.
module tb_nrzi_rx_decoder;

    localparam int W  = 8;
    localparam int SL = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_en = 1'b0;
    logic         bit_en = 1'b0;
    logic         line_in = 1'b1;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         stuff_err;
    logic         overrun;
    logic         state_dbg;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    bit           mon_en = 1'b0;
    bit           saw_stuff = 1'b0;
    bit           saw_ovr = 1'b0;

    // Encoder state: current line level and length of the current 1 run.
    logic         enc_prev = 1'b1;
    int           enc_ones = 0;

    nrzi_rx_decoder #(.WIDTH(W), .STUFF_LEN(SL), .IDLE_LEVEL(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en     (rx_en),
        .bit_en    (bit_en),
        .line_in   (line_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stuff_err (stuff_err),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sticky record of error pulses.
    always @(posedge clk) begin
        if (stuff_err) saw_stuff = 1'b1;
        if (overrun)   saw_ovr = 1'b1;
    end

    // Scoreboard: every accepted word must be the next expected payload.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL mon_word: got %h, required no word", out_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL mon_word: got %h, required %h", out_data, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input logic lvl, input int maxgap);
        bit_en  = 1'b1;
        line_in = lvl;
        tick();
        bit_en = 1'b0;
        repeat ($urandom_range(maxgap, 0)) tick();
    endtask

    // Encode one payload bit: a stuffed 0 first if the run is full, then
    // 1 = keep level, 0 = toggle level.
    task automatic send_bit(input logic b, input int maxgap);
        if (enc_ones == SL) begin
            enc_prev = ~enc_prev;
            send_line(enc_prev, maxgap);
            enc_ones = 0;
        end
        if (b) begin
            enc_ones++;
        end else begin
            enc_ones = 0;
            enc_prev = ~enc_prev;
        end
        send_line(enc_prev, maxgap);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int maxgap);
        for (int i = 0; i < W; i++) send_bit(w[i], maxgap);
    endtask

    task automatic restart_frame();
        rx_en = 1'b0;
        tick();
        rx_en = 1'b1;
        tick();
        enc_prev = 1'b1;
        enc_ones = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({out_valid, stuff_err, overrun, state_dbg} !== 4'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got v=%b s=%b o=%b st=%b d=%h, required all 0",
                     out_valid, stuff_err, overrun, state_dbg, out_data);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || state_dbg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got v=%b st=%b, required 0 0", out_valid, state_dbg);
        end
    endtask

    task automatic test_basic();
        logic lv[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b0;
        rx_en = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) send_line(lv[i], 0);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early: got valid=%b, required 0", out_valid);
        end
        send_line(lv[7], 0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'h8B) begin
            n_err++;
            $display("FAIL basic_word: got v=%b d=%h, required v=1 d=8b", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_accept: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_stuffing();
        restart_frame();
        saw_stuff = 1'b0;
        for (int k = 0; k < 2; k++) begin
            send_word(8'hFF, 0);
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 8'hFF || saw_stuff) begin
                n_err++;
                $display("FAIL stuff_word%0d: got v=%b d=%h serr=%b, required v=1 d=ff serr=0",
                         k, out_valid, out_data, saw_stuff);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_stuff_err();
        logic [W-1:0] w;
        restart_frame();
        for (int i = 0; i < SL; i++) send_line(1'b1, 0);
        send_line(1'b1, 0);
        n_vec++;
        if (stuff_err !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stuff_err_pulse: got serr=%b v=%b, required 1 0", stuff_err, out_valid);
        end
        tick();
        n_vec++;
        if (stuff_err !== 1'b0) begin
            n_err++;
            $display("FAIL stuff_err_width: got %b, required 0", stuff_err);
        end
        enc_prev = 1'b1;
        enc_ones = 0;
        w = W'($urandom);
        send_word(w, 0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== w) begin
            n_err++;
            $display("FAIL stuff_err_recover: got v=%b d=%h, required v=1 d=%h", out_valid, out_data, w);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_overrun();
        restart_frame();
        out_ready = 1'b0;
        send_word(8'hA5, 0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            n_err++;
            $display("FAIL ovr_first: got v=%b d=%h, required v=1 d=a5", out_valid, out_data);
        end
        send_word(8'h3C, 0);
        n_vec++;
        if (overrun !== 1'b1 || out_data !== 8'hA5 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_pulse: got o=%b v=%b d=%h, required o=1 v=1 d=a5",
                     overrun, out_valid, out_data);
        end
        tick();
        n_vec++;
        if (overrun !== 1'b0 || out_data !== 8'hA5) begin
            n_err++;
            $display("FAIL ovr_width: got o=%b d=%h, required o=0 d=a5", overrun, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_accept: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        restart_frame();
        saw_ovr = 1'b0;
        out_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(W'(i));
            send_word(W'(i), 0);
        end
        repeat (3) tick();
        mon_en = 1'b0;
        out_ready = 1'b0;
        n_vec++;
        if (exp_q.size() != 0 || saw_ovr) begin
            n_err++;
            $display("FAIL b2b_drain: got %0d left ovr=%b, required 0 left ovr=0", exp_q.size(), saw_ovr);
        end
        exp_q.delete();
    endtask

    task automatic test_abort();
        logic [W-1:0] w;
        restart_frame();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 0);
        restart_frame();
        w = W'($urandom);
        send_word(w, 0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== w) begin
            n_err++;
            $display("FAIL abort_rx_en: got v=%b d=%h, required v=1 d=%h", out_valid, out_data, w);
        end
        // Partial word plus a pending output, then an asynchronous reset.
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL abort_rst: got v=%b d=%h, required v=0 d=00", out_valid, out_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        enc_prev = 1'b1;
        enc_ones = 0;
        w = W'($urandom);
        send_word(w, 0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== w) begin
            n_err++;
            $display("FAIL abort_rst_next: got v=%b d=%h, required v=1 d=%h", out_valid, out_data, w);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        restart_frame();
        saw_stuff = 1'b0;
        saw_ovr = 1'b0;
        out_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] w;
            w = ($urandom_range(3, 0) == 0) ? W'(8'hFF) : W'($urandom);
            exp_q.push_back(w);
            send_word(w, $urandom_range(2, 0));
        end
        repeat (3) tick();
        mon_en = 1'b0;
        out_ready = 1'b0;
        n_vec++;
        if (exp_q.size() != 0 || saw_stuff || saw_ovr) begin
            n_err++;
            $display("FAIL random_drain: got %0d left serr=%b ovr=%b, required 0 0 0",
                     exp_q.size(), saw_stuff, saw_ovr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuffing();
        test_stuff_err();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
